// File: rtl/input_debounce.sv
// Input synchronizer plus two-state debounce filter producing a clean registered level.
// Define INPUT_DEBOUNCE_EDGE_EN to generate registered rise/fall pulses; otherwise they read 0.
module input_debounce #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic q,
    output logic busy,
    output logic rise,
    output logic fall
);

    typedef enum logic {STABLE, COUNT} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   q_q, q_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            q_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (s != q_q) begin
                    // A single-sample filter commits immediately and never counts.
                    if (STABLE_CYCLES == 1) begin
                        q_d = s;
                    end else begin
                        state_d = COUNT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            COUNT: begin
                if (s == q_q) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    q_d     = s;
                    state_d = STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign q    = q_q;
    assign busy = (state_q == COUNT);

`ifdef INPUT_DEBOUNCE_EDGE_EN
    logic rise_q, fall_q;

    // Pulses are registered from the same next-state as q so they line up with its change.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= q_d & ~q_q;
            fall_q <= ~q_d & q_q;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce: default instance plus a STABLE_CYCLES=1 instance.
module tb_input_debounce;

`ifdef INPUT_DEBOUNCE_EDGE_EN
    localparam logic EDGE = 1'b1;
`else
    localparam logic EDGE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, d_in, d1;
    logic q, busy, rise, fall;
    logic q1, busy1, rise1, fall1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    input_debounce #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .d_in(d_in), .q(q), .busy(busy), .rise(rise), .fall(fall)
    );

    input_debounce #(.SYNC_STAGES(2), .STABLE_CYCLES(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .d_in(d1), .q(q1), .busy(busy1), .rise(rise1), .fall(fall1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Checks q/busy/rise/fall of the default instance after one edge.
    task automatic step(input string tag, input logic eq, input logic eb,
                        input logic er, input logic ef);
        tick();
        chk({tag, ".q"}, q, eq);
        chk({tag, ".busy"}, busy, eb);
        chk({tag, ".rise"}, rise, er);
        chk({tag, ".fall"}, fall, ef);
    endtask

    initial begin
        rst  = 1'b1;
        d_in = 1'b1;
        d1   = 1'b0;
        for (int i = 0; i < 3; i++) step("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.q1", q1, 1'b0);
        chk("reset.busy1", busy1, 1'b0);

        // Release with d_in high: q rises at the 6th edge.
        rst = 1'b0;
        step("rel.e1", 1'b0, 1'b0, 1'b0, 1'b0);
        step("rel.e2", 1'b0, 1'b0, 1'b0, 1'b0);
        step("rel.e3", 1'b0, 1'b1, 1'b0, 1'b0);
        step("rel.e4", 1'b0, 1'b1, 1'b0, 1'b0);
        step("rel.e5", 1'b0, 1'b1, 1'b0, 1'b0);
        step("rel.e6", 1'b1, 1'b0, EDGE, 1'b0);
        step("rel.e7", 1'b1, 1'b0, 1'b0, 1'b0);

        // Clean falling step.
        d_in = 1'b0;
        step("fall.e1", 1'b1, 1'b0, 1'b0, 1'b0);
        step("fall.e2", 1'b1, 1'b0, 1'b0, 1'b0);
        step("fall.e3", 1'b1, 1'b1, 1'b0, 1'b0);
        step("fall.e4", 1'b1, 1'b1, 1'b0, 1'b0);
        step("fall.e5", 1'b1, 1'b1, 1'b0, 1'b0);
        step("fall.e6", 1'b0, 1'b0, 1'b0, EDGE);
        step("fall.e7", 1'b0, 1'b0, 1'b0, 1'b0);

        // Three-clock glitch: counted but never committed.
        d_in = 1'b1;
        step("glitch.e1", 1'b0, 1'b0, 1'b0, 1'b0);
        step("glitch.e2", 1'b0, 1'b0, 1'b0, 1'b0);
        step("glitch.e3", 1'b0, 1'b1, 1'b0, 1'b0);
        d_in = 1'b0;
        step("glitch.e4", 1'b0, 1'b1, 1'b0, 1'b0);
        step("glitch.e5", 1'b0, 1'b1, 1'b0, 1'b0);
        step("glitch.e6", 1'b0, 1'b0, 1'b0, 1'b0);
        step("glitch.e7", 1'b0, 1'b0, 1'b0, 1'b0);
        step("glitch.e8", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-count (cnt = 2) discards progress.
        d_in = 1'b1;
        step("mid.e1", 1'b0, 1'b0, 1'b0, 1'b0);
        step("mid.e2", 1'b0, 1'b0, 1'b0, 1'b0);
        step("mid.e3", 1'b0, 1'b1, 1'b0, 1'b0);
        step("mid.e4", 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        step("mid.rst", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step("mid.r1", 1'b0, 1'b0, 1'b0, 1'b0);
        step("mid.r2", 1'b0, 1'b0, 1'b0, 1'b0);
        step("mid.r3", 1'b0, 1'b1, 1'b0, 1'b0);
        step("mid.r4", 1'b0, 1'b1, 1'b0, 1'b0);
        step("mid.r5", 1'b0, 1'b1, 1'b0, 1'b0);
        step("mid.r6", 1'b1, 1'b0, EDGE, 1'b0);
        step("mid.r7", 1'b1, 1'b0, 1'b0, 1'b0);

        // STABLE_CYCLES = 1 instance: q follows s at edge 3, never busy.
        d1 = 1'b1;
        tick();
        chk("sc1.e1.q", q1, 1'b0);
        chk("sc1.e1.busy", busy1, 1'b0);
        tick();
        chk("sc1.e2.q", q1, 1'b0);
        chk("sc1.e2.busy", busy1, 1'b0);
        tick();
        chk("sc1.e3.q", q1, 1'b1);
        chk("sc1.e3.busy", busy1, 1'b0);
        chk("sc1.e3.rise", rise1, EDGE);
        chk("sc1.e3.fall", fall1, 1'b0);
        tick();
        chk("sc1.e4.q", q1, 1'b1);
        chk("sc1.e4.rise", rise1, 1'b0);
        d1 = 1'b0;
        tick();
        tick();
        chk("sc1.f2.q", q1, 1'b1);
        chk("sc1.f2.busy", busy1, 1'b0);
        tick();
        chk("sc1.f3.q", q1, 1'b0);
        chk("sc1.f3.fall", fall1, EDGE);
        chk("sc1.f3.rise", rise1, 1'b0);
        tick();
        chk("sc1.f4.fall", fall1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/input_debounce.md
INPUT_DEBOUNCE -- requirements
Module: input_debounce

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2: flops in the input synchronizer chain, legal range 2..4.
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 4: consecutive agreeing samples required before q changes, legal range 1..(2^CNT_W - 1).
REQ-003 The block SHALL have parameter CNT_W, default 4: stability counter width in bits.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port d_in, input, 1 bit: raw asynchronous level, e.g. a switch or an off-domain signal.
REQ-007 The block SHALL have port q, output, 1 bit: debounced, synchronized level, registered, fit to drive a downstream flop's d input.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a candidate level change is being counted.
REQ-009 The block SHALL have port rise, output, 1 bit: one-cycle pulse when q goes 0->1.
REQ-010 The block SHALL have port fall, output, 1 bit: one-cycle pulse when q goes 1->0.

Function
REQ-011 d_in SHALL pass through SYNC_STAGES flops; the last stage output s is the only form of d_in used by the rest of the logic.
REQ-012 The FSM SHALL have two states, STABLE and COUNT, with a counter cnt of CNT_W bits.
REQ-013 In STABLE with s == q, the FSM SHALL hold; cnt = 0.
REQ-014 In STABLE with s != q and STABLE_CYCLES > 1, the FSM SHALL go to COUNT with cnt = 1.
REQ-015 In STABLE with s != q and STABLE_CYCLES == 1, the FSM SHALL set q to s at that edge and stay in STABLE; COUNT is never entered.
REQ-016 In COUNT with s == q (glitch), the FSM SHALL return to STABLE with cnt = 0 and leave q unchanged.
REQ-017 In COUNT with s != q and cnt == STABLE_CYCLES-1, the FSM SHALL set q to s, go to STABLE and set cnt = 0.
REQ-018 In COUNT with s != q and cnt < STABLE_CYCLES-1, the FSM SHALL increment cnt; cnt never wraps.
REQ-019 Latency: after a clean d_in step set up before rising edge 1, q SHALL change at edge SYNC_STAGES+STABLE_CYCLES (6 with defaults).
REQ-020 busy SHALL equal (state == COUNT), decoded directly from the state register with no extra cycle of delay.
REQ-021 rise and fall SHALL be registered and SHALL assert in exactly the cycle in which q takes its new value; they SHALL never both be high.
REQ-022 A pulse narrower than STABLE_CYCLES samples of s SHALL never change q, rise or fall.

Reset
REQ-023 While rst is high at a rising edge, all synchronizer flops, q, cnt, rise and fall SHALL become 0 and the state SHALL become STABLE; busy then reads 0.
REQ-024 rst SHALL dominate every other condition; asserting it mid-COUNT SHALL discard the partial count with no rise or fall pulse.
REQ-025 If d_in is 1 throughout reset, q SHALL rise SYNC_STAGES+STABLE_CYCLES edges after the first edge with rst low, with one rise pulse.

Configuration
REQ-026 Macro INPUT_DEBOUNCE_EDGE_EN defined: rise and fall SHALL be generated per REQ-021.
REQ-027 Macro INPUT_DEBOUNCE_EDGE_EN undefined: rise and fall SHALL remain as ports tied to constant 0 with no edge registers; all other behaviour is unchanged.

Verification (defaults, INPUT_DEBOUNCE_EDGE_EN defined)
REQ-028 Reset and d_in = 1 held for 3 edges, then rst = 0 -> q = 0 during reset; q = 1 and rise = 1 at the 6th edge after release; rise = 0 on the next edge.
REQ-029 With q = 1 steady, d_in = 0 held indefinitely -> busy high from edge 3 through edge 5; q = 0 and fall = 1 at edge 6.
REQ-030 With q = 0, a d_in high pulse 3 clocks wide -> busy pulses; q, rise and fall stay 0.
REQ-031 With q = 0, d_in = 1 and rst asserted for one edge while cnt = 2 -> cnt = 0, no pulse; q rises 6 edges after rst drops.
REQ-032 STABLE_CYCLES = 1 and macro undefined: d_in step 0->1 -> q = 1 at edge 3, busy never high, rise and fall constant 0.
